store_buffer: RTL

- Posted-write buffer between the EX/MEM pipeline register and data_memory.
- Accepts stores from the MEM stage, queues them FIFO, and retires them to data_memory in idle memory cycles.
- Loads bypass the queue to memory; a load whose address matches a queued store gets the youngest matching data forwarded instead.
- The pipeline never waits on a store unless the buffer is full.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_match.sv | 48 ++++
 rtl/store_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module      : store_buffer_pkg
// Description : Default geometry shared by the store buffer and its matcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_buffer_pkg;

    localparam int c_def_depth  = 4;
    localparam int c_def_addr_w = 32;
    localparam int c_def_data_w = 32;

    // Pointer width for a power-of-two ring of the given depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_match.sv
// ============================================================================
// Module      : store_buffer_match
// Description : Parallel address compare over all entries, youngest-match
//               (closest to tail) priority select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = c_def_depth,
    parameter int ADDR_W = c_def_addr_w,
    parameter int PTR_W  = ptr_width(c_def_depth)
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [PTR_W-1:0]  tail,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [PTR_W-1:0]  index
);

    logic [DEPTH-1:0] w_match;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
            assign w_match[i] = valid[i] && (entry_addr[i] == ld_addr);
        end
    endgenerate

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        hit   = 1'b0;
        index = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = tail - PTR_W'(k);
            if (w_match[w_idx]) begin
                hit   = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between MEM stage and data_memory; retires
//               stores in idle memory cycles. STORE_BUF_FWD_EN enables
//               load forwarding (otherwise matching loads stall).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = c_def_depth,
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = c_def_data_w
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_hit,
    output logic                     ld_stall,
    input  logic                     drain_all,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_write_data,
    output logic                     mem_memwrite,
    output logic                     mem_memread,
    input  logic [DATA_W-1:0]        mem_read_data
);

    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_drain;
    logic               w_hit;
    logic               w_load_miss;
    logic [c_ptr_w-1:0] w_idx;

    store_buffer_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PTR_W  (c_ptr_w)
    ) u_match (
        .valid      (r_valid),
        .entry_addr (r_addr),
        .tail       (r_tail),
        .ld_addr    (ld_addr),
        .hit        (w_hit),
        .index      (w_idx)
    );

    assign w_full      = (r_count == c_cnt_w'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign st_ready    = !w_full && !drain_all;
    // The MEM port carries a single op; a store alongside a load is dropped.
    assign w_enq       = st_valid && st_ready && !ld_valid;
    assign w_load_miss = ld_valid && !w_hit;
    assign w_drain     = (!w_empty && !w_load_miss) || w_full;

`ifdef STORE_BUF_FWD_EN
    assign ld_hit   = ld_valid && w_hit;
    assign ld_stall = w_load_miss && w_full;
`else
    assign ld_hit   = 1'b0;
    assign ld_stall = (ld_valid && w_hit) || (w_load_miss && w_full);
`endif

    assign ld_data        = ld_hit ? r_data[w_idx] : mem_read_data;
    assign mem_memwrite   = w_drain;
    assign mem_memread    = w_load_miss && !w_full;
    assign mem_addr       = w_drain     ? r_addr[r_head] :
                            mem_memread ? ld_addr        : '0;
    assign mem_write_data = w_drain ? r_data[r_head] : '0;
    assign empty          = w_empty;
    assign count          = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

endmodule

`default_nettype wire
